// File: rtl/nbody_mem_dump.sv
// nbody_mem_dump: strided burst reader over a fixed-latency memory port, with a
// credit-limited output FIFO streaming words as valid/ready with index/last markers.
`default_nettype none

module nbody_mem_dump #(
    parameter int DATA_W     = 80,
    parameter int ADDR_W     = 15,
    parameter int CNT_W      = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] stride,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_index,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW:0] C_DEPTH = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr, stride_q;
    logic [CNT_W-1:0]  len, issued, load_idx;
    logic [RD_LAT-1:0] pipe;
    logic [PW-1:0]     in_flight, fcnt;
    logic [AW-1:0]     wptr, rptr;
    logic              aborting;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic [PW:0] occ_sum;
    logic        issue, ret, abort_eff, push, load_out, from_store, bypass, store_push, drained;

    // Credit covers in-flight reads plus every buffered word, output stage included.
    assign occ_sum    = {1'b0, in_flight} + {1'b0, fcnt} + (PW+1)'(out_valid);
    assign issue      = (state == S_ISSUE) && (occ_sum < C_DEPTH);
    assign ret        = pipe[RD_LAT-1];
    assign abort_eff  = abort && ((state == S_ISSUE) || (state == S_DRAIN));
    assign push       = ret && !aborting && !abort_eff;
    assign load_out   = !out_valid || out_ready;
    assign from_store = load_out && (fcnt != '0);
    assign bypass     = load_out && (fcnt == '0) && push;
    assign store_push = push && !bypass;
    assign drained    = (in_flight == '0) && (fcnt == '0) && (!out_valid || out_ready);

    assign mem_addr  = addr;
    assign mem_rd_en = issue;

    always_ff @(posedge clk) begin
        if (store_push) mem[wptr] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            stride_q  <= '0;
            len       <= '0;
            issued    <= '0;
            load_idx  <= '0;
            pipe      <= '0;
            in_flight <= '0;
            fcnt      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            aborting  <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            pipe[0] <= issue;
            for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];

            case ({issue, ret})
                2'b10:   in_flight <= in_flight + PW'(1);
                2'b01:   in_flight <= in_flight - PW'(1);
                default: in_flight <= in_flight;
            endcase

            done    <= 1'b0;
            aborted <= 1'b0;

            if (abort_eff) begin
                wptr      <= '0;
                rptr      <= '0;
                fcnt      <= '0;
                out_valid <= 1'b0;
            end else begin
                if (store_push) wptr <= wptr + AW'(1);
                if (from_store) begin
                    out_data <= mem[rptr];
                    rptr     <= rptr + AW'(1);
                end else if (bypass) begin
                    out_data <= mem_rdata;
                end
                if (from_store || bypass) begin
                    out_valid <= 1'b1;
                    out_index <= load_idx;
                    out_last  <= (load_idx == len - CNT_W'(1));
                    load_idx  <= load_idx + CNT_W'(1);
                end else if (load_out) begin
                    out_valid <= 1'b0;
                end
                case ({store_push, from_store})
                    2'b10:   fcnt <= fcnt + PW'(1);
                    2'b01:   fcnt <= fcnt - PW'(1);
                    default: fcnt <= fcnt;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr     <= base_addr;
                        stride_q <= stride;
                        len      <= count;
                        issued   <= '0;
                        load_idx <= '0;
                        aborting <= 1'b0;
                        busy     <= 1'b1;
                        if (count != '0) begin
                            state <= S_ISSUE;
                        end else begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        addr   <= addr + stride_q;
                        issued <= issued + CNT_W'(1);
                        if (issued == len - CNT_W'(1)) state <= S_DRAIN;
                    end
                    if (abort) begin
                        aborting <= 1'b1;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        aborting <= 1'b1;
                    end else if (aborting ? (in_flight == '0) : drained) begin
                        state   <= S_FINISH;
                        done    <= 1'b1;
                        aborted <= aborting;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_nbody_mem_dump.sv
// Directed testbench for nbody_mem_dump with a 2-cycle memory model returning data=addr.
`default_nettype none

module tb_nbody_mem_dump;
    localparam int DATA_W = 80;
    localparam int ADDR_W = 15;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start, abort, out_ready;
    logic [ADDR_W-1:0] base_addr, stride;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_index;
    logic              out_last, out_valid, busy, done, aborted;

    nbody_mem_dump dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .count(count), .stride(stride), .abort(abort), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // Memory model: read data equals the address, two cycles after the strobe.
    logic [ADDR_W-1:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        if (mem_rd_en) a1 <= mem_addr;
        a2 <= a1;
    end
    assign mem_rdata = {{(DATA_W-ADDR_W){1'b0}}, a2};

    // Stream monitor
    logic              mon_clr = 1'b0;
    logic [DATA_W-1:0] q_data[$];
    logic [CNT_W-1:0]  q_idx[$];
    logic              q_last[$];
    logic [ADDR_W-1:0] q_addr[$];
    int                n_rd, n_xfer, max_out, stall_err;
    logic              prev_stall;
    logic [DATA_W-1:0] pd;
    logic [CNT_W-1:0]  pi;
    logic              pl;
    always @(posedge clk) begin
        if (mon_clr) begin
            q_data.delete(); q_idx.delete(); q_last.delete(); q_addr.delete();
            n_rd = 0; n_xfer = 0; max_out = 0; stall_err = 0; prev_stall = 1'b0;
        end else if (reset_n) begin
            if (mem_rd_en) begin n_rd++; q_addr.push_back(mem_addr); end
            if (prev_stall && (!out_valid || out_data !== pd || out_index !== pi || out_last !== pl))
                stall_err++;
            if (out_valid && out_ready) begin
                n_xfer++;
                q_data.push_back(out_data); q_idx.push_back(out_index); q_last.push_back(out_last);
            end
            if (n_rd - n_xfer > max_out) max_out = n_rd - n_xfer;
            prev_stall = out_valid && !out_ready;
            pd = out_data; pi = out_index; pl = out_last;
        end
    end

    int  passed = 0, total = 0;
    bit  rp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    endtask

    task automatic chk_stream(input string tag, input logic [ADDR_W-1:0] b,
                              input int c, input logic [ADDR_W-1:0] s);
        logic [ADDR_W-1:0] e;
        chk({tag, "_nwords"}, q_data.size(), c);
        chk({tag, "_nreads"}, q_addr.size(), c);
        for (int i = 0; i < c; i++) begin
            e = b + ADDR_W'(i) * s;
            chk({tag, "_addr"}, (i < q_addr.size()) ? 128'(q_addr[i]) : 'x, e);
            chk({tag, "_data"}, (i < q_data.size()) ? 128'(q_data[i]) : 'x, e);
            chk({tag, "_index"}, (i < q_idx.size()) ? 128'(q_idx[i]) : 'x, i);
            chk({tag, "_last"}, (i < q_last.size()) ? 128'(q_last[i]) : 'x, (i == c - 1));
        end
    endtask

    task automatic burst(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c,
                         input logic [ADDR_W-1:0] s, input bit bp);
        bit seen = 1'b0;
        clr_mon();
        base_addr = b; count = c; stride = s; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            out_ready = bp ? rp[cyc % 4] : 1'b1;
            tick();
            if (done) seen = 1'b1;
        end
        chk("burst_done", seen, 1);
        chk("burst_not_aborted", aborted, 0);
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, k, dn, ab, first, x0, sv;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; count = '0; stride = '0;
        #12;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy_done", {busy, done, aborted}, 0);
        chk("rst_addr", mem_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Body dump with exact latency
        clr_mon();
        base_addr = 0; count = 5; stride = 1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("body_first_issue", {mem_rd_en, mem_addr}, {1'b1, 15'd0});
        chk("body_busy", busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        chk("body_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk("body_valid", out_valid, 1);
            chk("body_data", out_data, i);
            chk("body_index", out_index, i);
            chk("body_last", out_last, (i == 4));
            tick();
        end
        chk("body_done", {done, aborted, busy}, 3'b101);
        tick();
        chk("body_done_clear", {done, busy}, 2'b00);

        // Forces with backpressure
        burst(15'd400, 16'd5, 15'd1, 1'b1);
        chk_stream("force", 15'd400, 5, 15'd1);
        chk("force_stall_stable", stall_err, 0);
        chk("force_credit", (max_out <= 4), 1);

        // Address wrap, then stride 3
        burst(15'h7FFE, 16'd3, 15'd1, 1'b0);
        chk_stream("wrap", 15'h7FFE, 3, 15'd1);
        burst(15'd10, 16'd4, 15'd3, 1'b0);
        chk_stream("stride", 15'd10, 4, 15'd3);

        // count = 0
        clr_mon();
        count = 0; base_addr = 5; stride = 1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", {done, aborted}, 2'b10);
        tick();
        chk("zero_done_clear", {done, busy}, 2'b00);
        tick(); tick(); tick();
        chk("zero_no_traffic", {n_rd, n_xfer}, 0);

        // Start while busy is ignored
        clr_mon();
        base_addr = 100; count = 3; stride = 1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        base_addr = 200; count = 7; start = 1'b1;
        tick();
        start = 1'b0;
        sv = 0;
        for (int c = 0; c < 50 && sv == 0; c++) begin tick(); if (done) sv = 1; end
        chk("busy_start_done", sv, 1);
        tick(); tick(); tick();
        chk_stream("busy_start", 15'd100, 3, 15'd1);

        // Abort at the 6th issue
        clr_mon();
        base_addr = 0; count = 20; stride = 1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (mem_rd_en) n++;
            if (n == 6) break;
            tick();
        end
        chk("abort_reached_6", n, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        x0 = n_xfer;
        chk("abort_rd_en_low", mem_rd_en, 0);
        chk("abort_valid_low", out_valid, 0);
        dn = 0; ab = 0; first = -1;
        for (k = 1; k <= 12; k++) begin
            tick();
            if (done) begin dn++; if (aborted) ab++; if (first < 0) first = k; end
            if (out_valid) x0 = -100;
        end
        chk("abort_done_once", dn, 1);
        chk("abort_flag", ab, 1);
        chk("abort_done_timing", first, 3);
        chk("abort_no_output", n_xfer, x0);
        chk("abort_reads", n_rd, 6);
        burst(15'd50, 16'd2, 15'd1, 1'b0);
        chk_stream("post_abort", 15'd50, 2, 15'd1);

        // Reset mid-burst after 3 issues
        clr_mon();
        base_addr = 0; count = 10; stride = 1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (mem_rd_en) n++;
            if (n == 3) break;
            tick();
        end
        chk("rstmid_reached_3", n, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_outputs", {mem_rd_en, out_valid, out_last, busy, done, aborted}, 0);
        chk("rstmid_addr_idx", {mem_addr, out_index}, 0);
        chk("rstmid_data", out_data, 0);
        #1 reset_n = 1'b1;
        sv = 0; dn = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) sv++;
            if (done) dn++;
        end
        chk("rstmid_no_valid", sv, 0);
        chk("rstmid_no_done", dn, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
